// File: rtl/ps_shift_tx_if.sv
// Handshake and serial-output bundle for ps_shift_tx.
// The master side requests frames; the slave side is the transmitter.
interface ps_shift_tx_if #(
  parameter int DATA_W = 64
);
  logic              start;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              done;
  logic              ser_out;
  logic              ser_clk;

  modport master (
    output start, din,
    input  busy, done, ser_out, ser_clk
  );

  modport slave (
    input  start, din,
    output busy, done, ser_out, ser_clk
  );
endinterface

// File: rtl/ps_shift_tx.sv
// Parallel-in/serial-out frame transmitter: marker bit, payload bits, then idle level.
// Define PS_SHIFT_TX_PARITY_EN to append an even-parity bit after the payload.
module ps_shift_tx #(
  parameter int DATA_W    = 64,
  parameter int DIV       = 4,
  parameter int LSB_FIRST = 1,
  parameter bit IDLE_LVL  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  ps_shift_tx_if.slave bus
);

`ifdef PS_SHIFT_TX_PARITY_EN
  localparam int N = DATA_W + 2;
  localparam int BIT_W = $clog2(DATA_W + 3);
  localparam logic [BIT_W-1:0] PAR_SLOT = BIT_W'(DATA_W);
`else
  localparam int N = DATA_W + 1;
  localparam int BIT_W = $clog2(DATA_W + 3);
`endif
  localparam int DIV_W = $clog2(DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
`ifdef PS_SHIFT_TX_PARITY_EN
  logic              par;
`endif

  function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (LSB_FIRST != 0) begin
      r = v >> 1;
      r[DATA_W-1] = IDLE_LVL;
    end else begin
      r = v << 1;
      r[0] = IDLE_LVL;
    end
    return r;
  endfunction

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ser_out <= IDLE_LVL;
      bus.ser_clk <= 1'b0;
      sr       <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
`ifdef PS_SHIFT_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= SHIFT;
            bus.busy    <= 1'b1;
            bus.ser_out <= ~IDLE_LVL;
            bus.ser_clk <= 1'b0;
            sr          <= bus.din;
            div_cnt     <= '0;
            bit_cnt     <= '0;
`ifdef PS_SHIFT_TX_PARITY_EN
            par         <= ^bus.din;
`endif
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            // Bit-period boundary: either finish the frame or advance one bit
            div_cnt     <= '0;
            bus.ser_clk <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state       <= IDLE;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              bus.ser_out <= IDLE_LVL;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sr      <= shift_next(sr);
`ifdef PS_SHIFT_TX_PARITY_EN
              bus.ser_out <= (bit_cnt == PAR_SLOT) ? par : head_bit(sr);
`else
              bus.ser_out <= head_bit(sr);
`endif
            end
          end else begin
            div_cnt     <= div_cnt + 1'b1;
            bus.ser_clk <= (div_cnt + 1'b1) >= DIV_HALF;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_shift_tx.sv
// Scoreboard bench for ps_shift_tx: per-cycle expected {ser_out,busy,ser_clk,done}
// is queued when a frame is launched and compared at each falling edge.
module tb_ps_shift_tx;

`ifdef PS_SHIFT_TX_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif
  localparam int NA = 9 + PX;   // frame bits, 8-bit instances
  localparam int NC = 65 + PX;  // frame bits, 64-bit instance

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps_shift_tx_if #(.DATA_W(8))  ifa ();
  ps_shift_tx_if #(.DATA_W(8))  ifb ();
  ps_shift_tx_if #(.DATA_W(64)) ifc ();

  ps_shift_tx #(.DATA_W(8), .DIV(4), .LSB_FIRST(1), .IDLE_LVL(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  ps_shift_tx #(.DATA_W(8), .DIV(4), .LSB_FIRST(0), .IDLE_LVL(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  ps_shift_tx #(.DATA_W(64), .DIV(2), .LSB_FIRST(1), .IDLE_LVL(1'b0))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] sb[$];

  function automatic logic [3:0] get_obs(input int sel);
    case (sel)
      0:       return {ifa.ser_out, ifa.busy, ifa.ser_clk, ifa.done};
      1:       return {ifb.ser_out, ifb.busy, ifb.ser_clk, ifb.done};
      default: return {ifc.ser_out, ifc.busy, ifc.ser_clk, ifc.done};
    endcase
  endfunction

  task automatic set_in(input int sel, input logic s, input logic [63:0] d);
    case (sel)
      0:       begin ifa.start = s; ifa.din = d[7:0]; end
      1:       begin ifb.start = s; ifb.din = d[7:0]; end
      default: begin ifc.start = s; ifc.din = d;      end
    endcase
  endtask

  // Reference frame model built from the parameter set of the chosen instance
  function automatic void push_frame(input int sel, input logic [63:0] d, input bit tail);
    int dw; int div; bit lsb; logic idle; int n; int i;
    logic b; logic par; logic sc;
    dw   = (sel == 2) ? 64 : 8;
    div  = (sel == 2) ? 2 : 4;
    lsb  = (sel != 1);
    idle = (sel != 2);
    n    = 1 + dw + PX;
    par  = 1'b0;
    for (int j = 0; j < dw; j++) par ^= d[j];
    for (int c = 0; c < n * div; c++) begin
      i = c / div;
      if (i == 0)       b = ~idle;
      else if (i <= dw) b = lsb ? d[i-1] : d[dw-i];
      else              b = par;
      sc = ((c % div) >= (div / 2));
      sb.push_back({b, 1'b1, sc, 1'b0});
    end
    sb.push_back({idle, 1'b0, 1'b0, 1'b1});
    if (tail) sb.push_back({idle, 1'b0, 1'b0, 1'b0});
  endfunction

  task automatic test_reset();
    #12;
    n_cmp++;
    if (get_obs(0) !== 4'b1000) begin
      n_err++; $display("FAIL reset_a got %b want %b", get_obs(0), 4'b1000);
    end
    n_cmp++;
    if (get_obs(1) !== 4'b1000) begin
      n_err++; $display("FAIL reset_b got %b want %b", get_obs(1), 4'b1000);
    end
    n_cmp++;
    if (get_obs(2) !== 4'b0000) begin
      n_err++; $display("FAIL reset_c got %b want %b", get_obs(2), 4'b0000);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lsb_frame(input logic [63:0] d, input string tag);
    logic [3:0] e; int c;
    set_in(0, 1'b1, d); push_frame(0, d, 1'b1);
    @(negedge clk); set_in(0, 1'b0, d);
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_cmp++;
      if (get_obs(0) !== e) begin
        n_err++; $display("FAIL %s cyc %0d got %b want %b", tag, c, get_obs(0), e);
      end
      c++; @(negedge clk);
    end
  endtask

  task automatic test_msb_frame();
    logic [3:0] e; logic [3:0] o; logic prev; int c; int rises;
    set_in(1, 1'b1, 64'h01); push_frame(1, 64'h01, 1'b1);
    @(negedge clk); set_in(1, 1'b0, 64'h01);
    c = 0; rises = 0; prev = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = get_obs(1); n_cmp++;
      if (o !== e) begin
        n_err++; $display("FAIL msb_frame cyc %0d got %b want %b", c, o, e);
      end
      if (o[1] && !prev) rises++;
      prev = o[1];
      c++; @(negedge clk);
    end
    n_cmp++;
    if (rises != NA) begin
      n_err++; $display("FAIL msb_serclk_rises got %0d want %0d", rises, NA);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] e; int c;
    set_in(0, 1'b1, 64'h01);
    push_frame(0, 64'h01, 1'b0);
    push_frame(0, 64'h80, 1'b1);
    @(negedge clk); set_in(0, 1'b0, 64'h01);
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_cmp++;
      if (get_obs(0) !== e) begin
        n_err++; $display("FAIL back_to_back cyc %0d got %b want %b", c, get_obs(0), e);
      end
      if (c == 7)          set_in(0, 1'b1, 64'hFF);
      if (c == 8)          set_in(0, 1'b0, 64'hFF);
      if (c == NA * 4)     set_in(0, 1'b1, 64'h80);
      if (c == NA * 4 + 1) set_in(0, 1'b0, 64'h80);
      c++; @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] e; int c;
    set_in(0, 1'b1, 64'h01); push_frame(0, 64'h01, 1'b1);
    @(negedge clk); set_in(0, 1'b0, 64'h01);
    for (c = 0; c <= 12; c++) begin
      e = sb.pop_front(); n_cmp++;
      if (get_obs(0) !== e) begin
        n_err++; $display("FAIL pre_reset cyc %0d got %b want %b", c, get_obs(0), e);
      end
      if (c < 12) @(negedge clk);
    end
    sb.delete();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (get_obs(0) !== 4'b1000) begin
      n_err++; $display("FAIL async_reset got %b want %b", get_obs(0), 4'b1000);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); n_cmp++;
      if (get_obs(0) !== 4'b1000) begin
        n_err++; $display("FAIL reset_hold %0d got %b want %b", k, get_obs(0), 4'b1000);
      end
    end
    rst = 1'b0;
    @(negedge clk); n_cmp++;
    if (get_obs(0) !== 4'b1000) begin
      n_err++; $display("FAIL post_reset_idle got %b want %b", get_obs(0), 4'b1000);
    end
    test_lsb_frame(64'hA5, "after_reset");
  endtask

  task automatic test_parity();
    test_lsb_frame(64'h07, "parity_07");
    test_lsb_frame(64'h03, "parity_03");
  endtask

  task automatic test_wide();
    logic [3:0] e; int c;
    set_in(2, 1'b1, 64'h8000_0000_0000_0001);
    push_frame(2, 64'h8000_0000_0000_0001, 1'b1);
    @(negedge clk); set_in(2, 1'b0, 64'h0);
    c = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_cmp++;
      if (get_obs(2) !== e) begin
        n_err++; $display("FAIL wide cyc %0d got %b want %b", c, get_obs(2), e);
      end
      if (c == NC * 2) begin
        n_cmp++;
        if (get_obs(2) !== 4'b0001) begin
          n_err++; $display("FAIL wide_done got %b want %b", get_obs(2), 4'b0001);
        end
      end
      c++; @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_in(0, 1'b0, 64'h0);
    set_in(1, 1'b0, 64'h0);
    set_in(2, 1'b0, 64'h0);
    test_reset();
    test_lsb_frame(64'h01, "lsb_frame");
    test_msb_frame();
    test_back_to_back();
    test_async_reset();
    test_parity();
    test_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps_shift_tx.md
Name: ps_shift_tx

Overview:
Parametrised parallel-in/serial-out frame transmitter; generalises the fixed 65-bit load-and-shift register used to drive serial display and LED chains.
- Captures a DATA_W-bit word on start and emits a framed serial stream: marker bit, data bits, then idle level.
- Provides a programmable bit period, selectable bit order, a companion shift clock and a busy/done handshake.
- Sits between display/control logic and off-chip shift-register chains or a serial link.

Parameters:
DATA_W, 64, payload width in bits (>=1)
DIV, 4, clk cycles per serial bit (even, >=2)
LSB_FIRST, 1, 1 = din[0] sent first after marker; 0 = din[DATA_W-1] first
IDLE_LVL, 1, ser_out level when idle; marker bit = ~IDLE_LVL

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request to transmit din; sampled only when busy=0
din  input  DATA_W  parallel payload, captured on accepted start
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when a frame completes
ser_out  output  1  serial data
ser_clk  output  1  shift clock, rising edge mid-bit

Behaviour:
- Reset (async, rst=1): busy=0, done=0, ser_out=IDLE_LVL, ser_clk=0, shift register=0, bit and divider counters=0, FSM=IDLE. Reset mid-frame aborts the frame immediately; no done pulse.
- FSM states:
  - IDLE: waits for start.
  - SHIFT: frame in progress.
  - Transitions: IDLE->SHIFT on accepted start. SHIFT->IDLE after the last bit period.
  - done is a registered flag, not a state.
- Frame: N = 1 + DATA_W bits (N = 2 + DATA_W with the optional feature).
  - Bit 0: marker (~IDLE_LVL).
  - Bits 1..DATA_W: payload in the order set by LSB_FIRST.
- Accept: start=1 at rising edge k while busy=0. After edge k:
  - din is latched into the shift register.
  - busy=1 and ser_out=marker.
  - Divider and bit counters are cleared.
- Bit timing: frame bit i is driven on ser_out from edge k+i*DIV through the cycle before edge k+(i+1)*DIV.
- ser_clk: 0 for the first DIV/2 cycles of each bit period, 1 for the remaining DIV/2. It is 0 in IDLE.
- Completion: after edge k+N*DIV:
  - busy=0, ser_out=IDLE_LVL, done=1 for exactly one cycle.
- Back-to-back frames: start sampled at the edge where done is high is accepted, so frames can run back-to-back with no idle gap beyond that cycle.
- Ignored inputs: start while busy=1 is ignored (no queueing). Changes on din while busy have no effect.
- Shifting: a one-bit shift occurs on each bit-period boundary.
  - LSB_FIRST=1: right shift, fill with IDLE_LVL.
  - LSB_FIRST=0: left shift, fill with IDLE_LVL.
- Counter widths:
  - Divider counter: $clog2(DIV) bits, wraps from DIV-1 to 0.
  - Bit counter: $clog2(DATA_W+3) bits; no overflow possible within a frame.
- All outputs are registered; none is combinational from inputs.

Optional Feature:
Macro PS_SHIFT_TX_PARITY_EN.
- Defined: one extra bit follows the payload, before return to idle. It is even parity over the DATA_W payload bits: XOR of din as captured. Frame length N = DATA_W+2; done is delayed by DIV cycles.
- Undefined: no parity bit, N = DATA_W+1, and no parity logic is synthesised.

Test Plan:
1. DATA_W=8, DIV=4, LSB_FIRST=1, IDLE_LVL=1, din=8'h01, start pulse at edge k -> per 4-cycle period ser_out = 0,1,0,0,0,0,0,0,0. busy high from k to k+35. After edge k+36: done=1 one cycle, ser_out=1, busy=0.
2. Same din=8'h01 with LSB_FIRST=0 -> ser_out = 0,0,0,0,0,0,0,0,1, then idle 1. ser_clk shows 9 rising edges, each 2 cycles into its bit.
3. Start re-asserted at edge k+8 mid-frame with din=8'hFF -> ignored; stream unchanged from test 1. Start at the done cycle with din=8'h80 -> second frame begins at that edge with no gap.
4. rst asserted asynchronously at cycle k+13 -> busy=0, ser_out=1, ser_clk=0 immediately; no done pulse. A fresh start after reset release transmits normally.
5. PS_SHIFT_TX_PARITY_EN defined, DATA_W=8, din=8'h07 -> stream 0,1,1,1,0,0,0,0,0, then parity bit 1; done after edge k+40. din=8'h03 -> parity bit 0.
6. DATA_W=64, DIV=2, IDLE_LVL=0, din=64'h8000_0000_0000_0001, LSB_FIRST=1 -> marker 1, then 1, 62 zeros, 1, then idle 0. done after edge k+130.
